// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage and the Control decoder:
//   - MIPS opcode / funct encodings the decoder keys on
//   - default reset PC and the NOP word placed in an empty IF/ID
//   - fetch FSM state encoding
//   - branch offset helper (sign-extended word offset)
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  // Opcodes (instr[31:26]) and funct codes (instr[5:0]) used by Control.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  // FETCH: normal sequential fetch.
  // DROP : a wrong-path request is still outstanding; wait for its
  //        response, discard it, then resume at the saved target.
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_DROP  = 1'b1
  } fetch_state_e;

  // 16-bit immediate -> signed byte offset ({sext(imm), 2'b00}).
  function automatic logic signed [31:0] branch_offset(input logic [15:0] imm);
    return signed'({{14{imm[15]}}, imm, 2'b00});
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus.
//   imem_req   : fetch request, address held stable while high
//   imem_addr  : word-aligned fetch address
//   imem_valid : response strobe (may come in the same cycle as imem_req)
//   imem_rdata : instruction word, qualified by imem_valid
// master = fetch unit, slave = instruction memory.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_valid;
  logic [31:0]           imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit_next_pc_calc.sv
// Combinational redirect decision for the instruction held in IF/ID.
// Inputs : Control strobes jr/jump/beq/bne, ALU zero, rs_data, IF/ID instr + pc4.
// Outputs: redirect (a control transfer is requested) and tgt (word aligned).
// Priority is jr > jump > taken branch. The caller qualifies redirect with
// ifid_valid and stall.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  jr,
  input  logic                  jump,
  input  logic                  beq,
  input  logic                  bne,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] rs_data,
  input  logic [31:0]           ifid_instr,
  input  logic [ADDR_WIDTH-1:0] ifid_pc4,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] tgt
);

  logic                         br_taken;
  logic signed [ADDR_WIDTH-1:0] br_off_s;
  logic [ADDR_WIDTH-1:0]        br_tgt;
  logic [ADDR_WIDTH-1:0]        j_tgt;
  logic [ADDR_WIDTH-1:0]        raw_tgt;
  logic                         unused_opcode;

  // The opcode field is decoded by Control, not here.
  assign unused_opcode = ^ifid_instr[31:26];

  assign br_taken = (beq & zero) | (bne & ~zero);
  assign br_off_s = ADDR_WIDTH'(branch_offset(ifid_instr[15:0]));
  // Modulo-2^ADDR_WIDTH add; negative offsets wrap naturally.
  assign br_tgt   = ifid_pc4 + $unsigned(br_off_s);
  assign j_tgt    = {ifid_pc4[ADDR_WIDTH-1:28], ifid_instr[25:0], 2'b00};

  always_comb begin
    redirect = 1'b0;
    raw_tgt  = '0;
    if (jr) begin
      redirect = 1'b1;
      raw_tgt  = rs_data;
    end else if (jump) begin
      redirect = 1'b1;
      raw_tgt  = j_tgt;
    end else if (br_taken) begin
      redirect = 1'b1;
      raw_tgt  = br_tgt;
    end
  end

  // A misaligned JR register value is silently word aligned.
  assign tgt = {raw_tgt[ADDR_WIDTH-1:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage.
// Owns the PC, fetches over a one-outstanding req/valid handshake, and holds
// the IF/ID register feeding the decoder. Control redirects (JR, J/JAL, taken
// BEQ/BNE) flush IF/ID; a wrong-path request still in flight is drained in
// the DROP state and its response discarded.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem (master)     : instruction memory request/response bus
//   stall             : hazard hold, freezes PC / IF/ID / FSM
//   ifid_valid/instr/pc4 : IF/ID register (instr is NOP 0 when not valid)
//   jump, jr, beq, bne, zero, rs_data : Control + ALU redirect inputs
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_unit_if.master          imem,
  input  logic                  stall,
  output logic                  ifid_valid,
  output logic [31:0]           ifid_instr,
  output logic [ADDR_WIDTH-1:0] ifid_pc4,
  input  logic                  jump,
  input  logic                  jr,
  input  logic                  beq,
  input  logic                  bne,
  input  logic                  zero,
  input  logic [ADDR_WIDTH-1:0] rs_data
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] PC_RESET = RESET_PC[ADDR_WIDTH-1:0];

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  pending_q, pending_d;
  logic                  ifid_valid_q, ifid_valid_d;
  logic [31:0]           ifid_instr_q, ifid_instr_d;
  logic [ADDR_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;

  logic                  req;
  logic                  fire;
  logic                  take;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] tgt;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  next_pc_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_next_pc (
    .jr         (jr),
    .jump       (jump),
    .beq        (beq),
    .bne        (bne),
    .zero       (zero),
    .rs_data    (rs_data),
    .ifid_instr (ifid_instr_q),
    .ifid_pc4   (ifid_pc4_q),
    .redirect   (redirect),
    .tgt        (tgt)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  // A raised request stays up until its response (pending_q), and is held in
  // DROP regardless of stall. Reset overrides everything.
  assign req  = ~reset & ((state_q == ST_DROP) | pending_q | ~stall);
  assign fire = req & imem.imem_valid;
  assign take = ifid_valid_q & ~stall & redirect;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    // A response while stalled is dropped; the PC did not move, so the same
    // word is simply requested again after the stall.
    pending_d    = req & ~imem.imem_valid;

    if (!stall) begin
      unique case (state_q)
        ST_FETCH: begin
          if (take) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
            if (imem.imem_valid) begin
              // Wrong-path response in the redirect cycle: discard it.
              pc_d = tgt;
            end else begin
              // Request is out on the bus; keep its address until it returns.
              state_d = ST_DROP;
              tgt_d   = tgt;
            end
          end else if (fire) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = imem.imem_rdata;
            ifid_pc4_d   = pc_plus4;
            pc_d         = pc_plus4;
          end else begin
            // Decode consumed IF/ID and nothing new arrived: bubble.
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
          end
        end
        ST_DROP: begin
          if (take) begin
            tgt_d        = tgt;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
          end
          if (imem.imem_valid) begin
            pc_d    = take ? tgt : tgt_q;
            state_d = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      pc_q         <= PC_RESET;
      tgt_q        <= PC_RESET;
      pending_q    <= 1'b0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP;
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      pending_q    <= pending_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc4       = ifid_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] A0   = 32'h2008_0001;
  localparam logic [31:0] A1   = 32'h2009_0002;
  localparam logic [31:0] A2   = 32'h200A_0003;
  localparam logic [31:0] A3   = 32'h200B_0004;
  localparam logic [31:0] JMP  = 32'h0810_0010;  // J index 0x0100010
  localparam logic [31:0] JMP2 = 32'h0810_0020;  // J index 0x0100020
  localparam logic [31:0] BEQ  = 32'h1000_FFFF;  // beq imm -1
  localparam logic [31:0] BNE  = 32'h1400_0002;  // bne imm +2
  localparam logic [31:0] JRI  = 32'h03E0_0008;  // jr $ra
  localparam logic [31:0] BAD  = 32'hDEAD_BEEF;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        jump, jr, beq, bne, zero;
  logic [31:0] rs_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;

  int checks = 0;
  int errors = 0;

  fetch_unit_if #(.ADDR_WIDTH(32)) imem ();

  fetch_unit #(
    .RESET_PC   (32'h0040_0000),
    .ADDR_WIDTH (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem       (imem.master),
    .stall      (stall),
    .ifid_valid (ifid_valid),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .jump       (jump),
    .jr         (jr),
    .beq        (beq),
    .bne        (bne),
    .zero       (zero),
    .rs_data    (rs_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, vld;
    logic [31:0] rdata;
    logic        jmp, jrr, bq, bn, zr;
    logic [31:0] rs;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ifv;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        chk_pc4;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic stl, input logic vld, input logic [31:0] rdata,
    input logic jmp, input logic jrr, input logic bq, input logic bn, input logic zr,
    input logic [31:0] rs, input logic exp_req, input logic [31:0] exp_addr,
    input logic exp_ifv, input logic [31:0] exp_instr, input logic [31:0] exp_pc4,
    input logic chk_pc4);
    vec_t v;
    v.rst = rst; v.stl = stl; v.vld = vld; v.rdata = rdata;
    v.jmp = jmp; v.jrr = jrr; v.bq = bq; v.bn = bn; v.zr = zr; v.rs = rs;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_ifv = exp_ifv;
    v.exp_instr = exp_instr; v.exp_pc4 = exp_pc4; v.chk_pc4 = chk_pc4;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, check bus before the edge, IF/ID after it.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    reset = v.rst; stall = v.stl;
    imem.imem_valid = v.vld; imem.imem_rdata = v.rdata;
    jump = v.jmp; jr = v.jrr; beq = v.bq; bne = v.bn; zero = v.zr; rs_data = v.rs;
    #1;
    chk({tag, ".req"}, {31'b0, imem.imem_req}, {31'b0, v.exp_req});
    chk({tag, ".addr"}, imem.imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    chk({tag, ".ifv"}, {31'b0, ifid_valid}, {31'b0, v.exp_ifv});
    chk({tag, ".instr"}, ifid_instr, v.exp_instr);
    if (v.chk_pc4) chk({tag, ".pc4"}, ifid_pc4, v.exp_pc4);
  endtask

  vec_t tbl [20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0;
    imem.imem_valid = 1'b0; imem.imem_rdata = '0;
    jump = 0; jr = 0; beq = 0; bne = 0; zero = 0; rs_data = '0;

    //           rst stl vld rdata  jmp jr bq bn zr rs           req addr          ifv instr  pc4          cp
    // zero-latency fetch, J redirect with one bubble
    tbl[0]  = mk(0, 0, 1, A0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0000, 1, A0,   32'h0040_0004, 1);
    tbl[1]  = mk(0, 0, 1, JMP,  0, 0, 0, 0, 0, 0,            1, 32'h0040_0004, 1, JMP,  32'h0040_0008, 1);
    tbl[2]  = mk(0, 0, 1, BAD,  1, 0, 0, 0, 0, 0,            1, 32'h0040_0008, 0, 0,    0,             0);
    tbl[3]  = mk(0, 0, 1, A1,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0040, 1, A1,   32'h0040_0044, 1);
    // reset in the middle of running
    tbl[4]  = mk(1, 0, 0, 0,    0, 0, 0, 0, 0, 0,            0, 32'h0040_0044, 0, 0,    0,             1);
    // BEQ taken (to itself) then not taken
    tbl[5]  = mk(0, 0, 1, A0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0000, 1, A0,   32'h0040_0004, 1);
    tbl[6]  = mk(0, 0, 1, A1,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0004, 1, A1,   32'h0040_0008, 1);
    tbl[7]  = mk(0, 0, 1, A2,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0008, 1, A2,   32'h0040_000C, 1);
    tbl[8]  = mk(0, 0, 1, BEQ,  0, 0, 0, 0, 0, 0,            1, 32'h0040_000C, 1, BEQ,  32'h0040_0010, 1);
    tbl[9]  = mk(0, 0, 1, BAD,  0, 0, 1, 0, 1, 0,            1, 32'h0040_0010, 0, 0,    0,             0);
    tbl[10] = mk(0, 0, 1, BEQ,  0, 0, 0, 0, 0, 0,            1, 32'h0040_000C, 1, BEQ,  32'h0040_0010, 1);
    tbl[11] = mk(0, 0, 1, A3,   0, 0, 1, 0, 0, 0,            1, 32'h0040_0010, 1, A3,   32'h0040_0014, 1);
    // BNE taken forward
    tbl[12] = mk(0, 0, 1, BNE,  0, 0, 0, 0, 0, 0,            1, 32'h0040_0014, 1, BNE,  32'h0040_0018, 1);
    tbl[13] = mk(0, 0, 1, BAD,  0, 0, 0, 1, 0, 0,            1, 32'h0040_0018, 0, 0,    0,             0);
    tbl[14] = mk(0, 0, 1, A0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0020, 1, A0,   32'h0040_0024, 1);
    // jr beats jump; misaligned rs is word aligned
    tbl[15] = mk(0, 0, 1, BAD,  1, 1, 0, 0, 0, 32'h0040_0103, 1, 32'h0040_0024, 0, 0,   0,             0);
    tbl[16] = mk(0, 0, 1, A1,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0100, 1, A1,   32'h0040_0104, 1);
    // stall with idle bus, then a slow response
    tbl[17] = mk(0, 1, 0, 0,    0, 0, 0, 0, 0, 0,            0, 32'h0040_0104, 1, A1,   32'h0040_0104, 1);
    tbl[18] = mk(0, 0, 0, 0,    0, 0, 0, 0, 0, 0,            1, 32'h0040_0104, 0, 0,    0,             0);
    tbl[19] = mk(0, 0, 1, A2,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0104, 1, A2,   32'h0040_0108, 1);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req", {31'b0, imem.imem_req}, 32'd0);
    chk("rst.addr", imem.imem_addr, 32'h0040_0000);
    chk("rst.ifv", {31'b0, ifid_valid}, 32'd0);
    chk("rst.instr", ifid_instr, 32'd0);
    chk("rst.pc4", ifid_pc4, 32'd0);

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // 3-cycle latency memory, JR while request outstanding -> DROP
    apply(mk(0, 0, 1, JRI, 0, 0, 0, 0, 0, 0,            1, 32'h0040_0108, 1, JRI, 32'h0040_010C, 1), "drop1");
    apply(mk(0, 0, 0, 0,   0, 1, 0, 0, 0, 32'h0040_0100, 1, 32'h0040_010C, 0, 0,  0, 0), "drop2");
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_010C, 0, 0,   0, 0), "drop3");
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_010C, 0, 0,   0, 0), "drop4");
    apply(mk(0, 0, 1, BAD, 0, 0, 0, 0, 0, 0,            1, 32'h0040_010C, 0, 0,   0, 0), "drop5");
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0,            1, 32'h0040_0100, 0, 0,   0, 0), "drop6");
    apply(mk(0, 0, 1, A3,  0, 0, 0, 0, 0, 0,            1, 32'h0040_0100, 1, A3,  32'h0040_0104, 1), "drop7");

    // stall held 3 cycles with jump asserted
    apply(mk(0, 0, 1, JMP2, 0, 0, 0, 0, 0, 0, 1, 32'h0040_0104, 1, JMP2, 32'h0040_0108, 1), "stl1");
    for (int k = 0; k < 3; k++)
      apply(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0040_0108, 1, JMP2, 32'h0040_0108, 1),
            $sformatf("stl_hold%0d", k));
    apply(mk(0, 0, 1, BAD, 1, 0, 0, 0, 0, 0, 1, 32'h0040_0108, 0, 0,  0, 0), "stl_rel");
    apply(mk(0, 0, 1, A0,  0, 0, 0, 0, 0, 0, 1, 32'h0040_0080, 1, A0, 32'h0040_0084, 1), "stl_tgt");

    // reset while a request is outstanding; late response ignored
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 32'h0040_0084, 0, 0,  0, 0), "rw1");
    apply(mk(1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 32'h0040_0084, 0, 0,  0, 1), "rw2");
    apply(mk(1, 0, 1, BAD, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000, 0, 0,  0, 1), "rw3");
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 0, 0,  0, 1), "rw4");
    apply(mk(0, 0, 1, A1,  0, 0, 0, 0, 0, 0, 1, 32'h0040_0000, 1, A1, 32'h0040_0004, 1), "rw5");

    // PC wrap 0xFFFFFFFC + 4 -> 0
    apply(mk(0, 0, 1, JRI, 0, 0, 0, 0, 0, 0,            1, 32'h0040_0004, 1, JRI, 32'h0040_0008, 1), "wrap1");
    apply(mk(0, 0, 1, BAD, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h0040_0008, 0, 0,  0, 0), "wrap2");
    apply(mk(0, 0, 1, A2,  0, 0, 0, 0, 0, 0,            1, 32'hFFFF_FFFC, 1, A2,  32'h0000_0000, 1), "wrap3");
    apply(mk(0, 0, 0, 0,   0, 0, 0, 0, 0, 0,            1, 32'h0000_0000, 0, 0,   0, 0), "wrap4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
